// File: rtl/ahb_lite_arbiter.sv
// AHB-Lite arbiter: N_MST managers share one subordinate, round-robin with hold limit.
// Define AHB_ARB_FIXED_PRIO_EN for lowest-index-wins fixed priority instead.
module ahb_lite_arbiter #(
   parameter int N_MST    = 2,
   parameter int MAX_HOLD = 4
) (
   input  logic                HCLK,
   input  logic                HRESET,
   input  logic [N_MST-1:0]    m_req,
   input  logic [N_MST*16-1:0] m_haddr,
   input  logic [N_MST*2-1:0]  m_htrans,
   input  logic [N_MST-1:0]    m_hwrite,
   input  logic [N_MST*3-1:0]  m_hsize,
   input  logic [N_MST*3-1:0]  m_hburst,
   input  logic [N_MST*4-1:0]  m_hprot,
   input  logic [N_MST*32-1:0] m_hwdata,
   output logic [N_MST-1:0]    m_gnt,
   output logic                m_hready,
   output logic                m_hresp,
   output logic [31:0]         m_hrdata,
   output logic                HSEL,
   output logic [15:0]         HADDR,
   output logic [1:0]          HTRANS,
   output logic                HWRITE,
   output logic [2:0]          HSIZE,
   output logic [2:0]          HBURST,
   output logic [3:0]          HPROT,
   output logic [31:0]         HWDATA,
   output logic                HREADY,
   input  logic                HREADYOUT,
   input  logic                HRESP,
   input  logic [31:0]         HRDATA
);

   localparam int IW = $clog2(N_MST);

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   typedef enum logic {PARK, OWN} st_t;

   st_t              st;
   logic [N_MST-1:0] gnt;
   logic [N_MST-1:0] gnt_nxt;
   logic [IW-1:0]    own_idx;
   logic [IW-1:0]    nxt_idx;
   logic [IW-1:0]    dp_owner;
   logic             dp_valid;
   logic [3:0]       beats;
   logic [3:0]       blen;
   logic [3:0]       rem_after;
   logic             lock;
   logic             stay;

   assign m_gnt    = gnt;
   assign m_hready = HREADYOUT;
   assign HREADY   = HREADYOUT;
   assign m_hresp  = HRESP;
   assign m_hrdata = HRDATA;

   always_comb begin
      own_idx = '0;
      for (int i = 0; i < N_MST; i++)
         if (gnt[i]) own_idx = IW'(i);
   end

   always_comb begin
      HSEL   = 1'b0;
      HADDR  = '0;
      HTRANS = T_IDLE;
      HWRITE = 1'b0;
      HSIZE  = '0;
      HBURST = '0;
      HPROT  = '0;
      if (st == OWN) begin
         HSEL = 1'b1;
         for (int i = 0; i < N_MST; i++)
            if (gnt[i]) begin
               HADDR  = m_haddr[16*i +: 16];
               HTRANS = m_htrans[2*i +: 2];
               HWRITE = m_hwrite[i];
               HSIZE  = m_hsize[3*i +: 3];
               HBURST = m_hburst[3*i +: 3];
               HPROT  = m_hprot[4*i +: 4];
            end
      end
   end

   // Beats still owed after the current phase; a fixed-length burst
   // stays locked until its final beat is accepted.
   always_comb begin
      case (HBURST[2:1])
         2'b01:   blen = 4'd3;
         2'b10:   blen = 4'd7;
         2'b11:   blen = 4'd15;
         default: blen = 4'd0;
      endcase
      rem_after = '0;
      case (HTRANS)
         T_NONSEQ: rem_after = blen;
         T_SEQ:    rem_after = (beats != 4'd0) ? beats - 4'd1 : 4'd0;
         T_BUSY:   rem_after = beats;
         default:  rem_after = '0;
      endcase
      lock = (HTRANS == T_SEQ && HBURST == 3'b001) ||
             (rem_after != 4'd0);
   end

`ifdef AHB_ARB_FIXED_PRIO_EN
   always_comb begin
      nxt_idx = '0;
      for (int i = N_MST - 1; i >= 0; i--)
         if (m_req[i]) nxt_idx = IW'(i);
      stay = lock;
   end
`else
   localparam logic [3:0]    HOLD_TOP = 4'(MAX_HOLD - 1);
   localparam logic [IW-1:0] LAST_RST = IW'(N_MST - 1);

   logic [IW-1:0] last;
   logic [3:0]    hold_cnt;
   logic          o_req;
   logic          others;
   int            rr_c;

   always_comb begin
      o_req  = |(m_req & gnt);
      others = |(m_req & ~gnt);
      stay   = lock || (o_req && (!others || hold_cnt < HOLD_TOP));
   end

   // Scan last+1 .. last; the smallest offset wins, owner comes last.
   always_comb begin
      nxt_idx = '0;
      rr_c    = 0;
      for (int k = N_MST; k >= 1; k--) begin
         rr_c = (int'(last) + k) % N_MST;
         if (m_req[IW'(rr_c)]) nxt_idx = IW'(rr_c);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         last     <= LAST_RST;
         hold_cnt <= '0;
      end else if (HREADYOUT) begin
         if (gnt_nxt != gnt) begin
            hold_cnt <= '0;
            if (|gnt_nxt) last <= nxt_idx;
         end else if (!others) begin
            hold_cnt <= '0;
         end else if (st == OWN && HTRANS[1] && hold_cnt != HOLD_TOP) begin
            hold_cnt <= hold_cnt + 4'd1;
         end
      end
   end
`endif

   always_comb begin
      gnt_nxt = '0;
      if (st == OWN && stay)
         gnt_nxt = gnt;
      else if (|m_req)
         gnt_nxt[nxt_idx] = 1'b1;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         st       <= PARK;
         gnt      <= '0;
         dp_owner <= '0;
         dp_valid <= 1'b0;
         beats    <= '0;
      end else if (HREADYOUT) begin
         st       <= (|gnt_nxt) ? OWN : PARK;
         gnt      <= gnt_nxt;
         dp_owner <= own_idx;
         dp_valid <= (st == OWN) && HTRANS[1];
         beats    <= rem_after;
      end
   end

   always_comb begin
      HWDATA = '0;
      for (int i = 0; i < N_MST; i++)
         if (dp_valid && dp_owner == IW'(i))
            HWDATA = m_hwdata[32*i +: 32];
   end

endmodule

// File: tb/tb_ahb_lite_arbiter.sv
// Bench for ahb_lite_arbiter: scoreboard of expected slave transfers
// checked by a negedge monitor, plus direct grant checks.
module tb_ahb_lite_arbiter;

   localparam int N = 2;

   logic          HCLK;
   logic          HRESET;
   logic [N-1:0]  m_req;
   logic [N*16-1:0] m_haddr;
   logic [N*2-1:0]  m_htrans;
   logic [N-1:0]  m_hwrite;
   logic [N*3-1:0]  m_hsize;
   logic [N*3-1:0]  m_hburst;
   logic [N*4-1:0]  m_hprot;
   logic [N*32-1:0] m_hwdata;
   logic [N-1:0]  m_gnt;
   logic          m_hready;
   logic          m_hresp;
   logic [31:0]   m_hrdata;
   logic          HSEL;
   logic [15:0]   HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [2:0]    HBURST;
   logic [3:0]    HPROT;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic          HREADYOUT;
   logic          HRESP;
   logic [31:0]   HRDATA;

   ahb_lite_arbiter #(.N_MST(N), .MAX_HOLD(4)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .m_req(m_req), .m_haddr(m_haddr), .m_htrans(m_htrans),
      .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst),
      .m_hprot(m_hprot), .m_hwdata(m_hwdata),
      .m_gnt(m_gnt), .m_hready(m_hready), .m_hresp(m_hresp),
      .m_hrdata(m_hrdata),
      .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .HRDATA(HRDATA)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_tot = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge HCLK);
      #1;
   endtask

   typedef struct {
      int          mst;
      logic [15:0] addr;
      logic [1:0]  trans;
      logic        wr;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];

   task automatic push(input int m, input logic [15:0] a,
                       input logic [1:0] t, input logic w,
                       input logic [31:0] d);
      exp_t e;
      e.mst = m; e.addr = a; e.trans = t; e.wr = w; e.data = d;
      sb.push_back(e);
   endtask

   task automatic drv(input int m, input logic r, input logic [1:0] t,
                      input logic [15:0] a, input logic w,
                      input logic [2:0] b);
      m_req[m]            = r;
      m_htrans[2*m +: 2]  = t;
      m_haddr[16*m +: 16] = a;
      m_hwrite[m]         = w;
      m_hburst[3*m +: 3]  = b;
   endtask

   task automatic wait_gnt(input int m);
      int n = 0;
      while (!m_gnt[m] && n < 20) begin
         cyc(1);
         n++;
      end
      chk("gnt_wait", 32'(m_gnt[m]), 32'd1);
   endtask

   // slave memory
   logic [31:0] mem [256];
   logic [7:0]  s_addr;
   logic        s_wr;
   logic        s_pend;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      s_addr = '0;
      s_wr   = 1'b0;
      s_pend = 1'b0;
   end

   always @(posedge HCLK) begin
      if (HRESET) s_pend <= 1'b0;
      else if (HREADYOUT) begin
         if (s_pend && s_wr) mem[s_addr] <= HWDATA;
         s_pend <= HSEL && HTRANS[1];
         s_addr <= HADDR[9:2];
         s_wr   <= HWRITE;
      end
   end

   assign HRDATA = mem[s_addr];
   assign HRESP  = 1'b0;

   // monitor
   exp_t        mon_e;
   logic        dp_pend = 1'b0;
   logic        dp_wr   = 1'b0;
   logic [31:0] dp_exp  = '0;

   always @(negedge HCLK) begin
      if (HRESET) dp_pend = 1'b0;
      else if (HREADYOUT) begin
         if (dp_pend) begin
            if (dp_wr) chk("hwdata", HWDATA, dp_exp);
            else       chk("hrdata", m_hrdata, dp_exp);
            dp_pend = 1'b0;
         end
         if (HSEL && HTRANS[1]) begin
            if (sb.size() == 0) chk("unexp_xfer", 32'(sb.size()), 32'd1);
            else begin
               mon_e = sb.pop_front();
               chk("owner", 32'(m_gnt), 32'd1 << mon_e.mst);
               chk("haddr", 32'(HADDR), 32'(mon_e.addr));
               chk("htrans", 32'(HTRANS), 32'(mon_e.trans));
               chk("hwrite", 32'(HWRITE), 32'(mon_e.wr));
               dp_pend = 1'b1;
               dp_wr   = mon_e.wr;
               dp_exp  = mon_e.data;
            end
         end
      end
   end

   task automatic single(input int m, input logic [15:0] a,
                         input logic w, input logic [31:0] d);
      push(m, a, 2'b10, w, d);
      drv(m, 1'b1, 2'b10, a, w, 3'b000);
      m_hwdata[32*m +: 32] = d;
      wait_gnt(m);
      chk("s_haddr", 32'(HADDR), 32'(a));
      chk("s_htrans", 32'(HTRANS), 32'd2);
      cyc(1);
      drv(m, 1'b0, 2'b00, a, w, 3'b000);
      if (w) chk("s_hwdata", HWDATA, d);
      cyc(2);
   endtask

   int          fair_seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
   logic [15:0] bl_addr  [7] = '{16'h0500, 16'h0504, 16'h0508,
                                 16'h0510, 16'h0514, 16'h0518, 16'h051C};
   logic [1:0]  bl_tr    [7] = '{2'b10, 2'b10, 2'b10,
                                 2'b10, 2'b11, 2'b11, 2'b11};
   logic [2:0]  bl_bu    [7] = '{3'd0, 3'd0, 3'd0,
                                 3'd3, 3'd3, 3'd3, 3'd3};

   initial begin
      #100000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1);
   end

   initial begin
      HRESET    = 1'b1;
      HREADYOUT = 1'b1;
      m_req     = '1;
      m_haddr   = '0;
      m_htrans  = '0;
      m_hwrite  = '0;
      m_hsize   = '0;
      m_hburst  = '0;
      m_hprot   = '0;
      m_hwdata  = '0;
      cyc(2);
      chk("rst_gnt", 32'(m_gnt), 32'd0);
      chk("rst_hsel", 32'(HSEL), 32'd0);
      chk("rst_htrans", 32'(HTRANS), 32'd0);
      chk("rst_haddr", 32'(HADDR), 32'd0);
      chk("rst_hwdata", HWDATA, 32'd0);
      HRESET = 1'b0;
      cyc(1);
      chk("rel_gnt", 32'(m_gnt), 32'd1);
      m_req = '0;
      cyc(1);
      chk("park_gnt", 32'(m_gnt), 32'd0);
      chk("park_hsel", 32'(HSEL), 32'd0);

      single(1, 16'h0010, 1'b1, 32'hDEADBEEF);
      single(1, 16'h0010, 1'b0, 32'hDEADBEEF);

`ifndef AHB_ARB_FIXED_PRIO_EN
      for (int k = 0; k < 9; k++)
         push(fair_seq[k], (fair_seq[k] == 0) ? 16'h0100 : 16'h0200,
              2'b10, 1'b1,
              (fair_seq[k] == 0) ? 32'h11111111 : 32'h22222222);
      m_hwdata[31:0]  = 32'h11111111;
      m_hwdata[63:32] = 32'h22222222;
      drv(0, 1'b1, 2'b10, 16'h0100, 1'b1, 3'b000);
      drv(1, 1'b1, 2'b10, 16'h0200, 1'b1, 3'b000);
      cyc(10);
      drv(0, 1'b0, 2'b00, 16'h0100, 1'b1, 3'b000);
      drv(1, 1'b0, 2'b00, 16'h0200, 1'b1, 3'b000);
      cyc(3);
      chk("fair_sb", 32'(sb.size()), 32'd0);
`endif

      // wait states with a request swap during the stall
      push(0, 16'h0300, 2'b10, 1'b1, 32'h33333333);
      m_hwdata[31:0] = 32'h33333333;
      drv(0, 1'b1, 2'b10, 16'h0300, 1'b1, 3'b000);
      wait_gnt(0);
      cyc(1);
      HREADYOUT = 1'b0;
      drv(0, 1'b0, 2'b00, 16'h0300, 1'b1, 3'b000);
      push(1, 16'h0400, 2'b10, 1'b1, 32'h44444444);
      m_hwdata[63:32] = 32'h44444444;
      drv(1, 1'b1, 2'b10, 16'h0400, 1'b1, 3'b000);
      for (int k = 0; k < 3; k++) begin
         chk("ws_gnt", 32'(m_gnt), 32'd1);
         chk("ws_hready", 32'(HREADY), 32'd0);
         cyc(1);
      end
      HREADYOUT = 1'b1;
      chk("ws_last", 32'(m_gnt), 32'd1);
      cyc(1);
      chk("ws_hand", 32'(m_gnt), 32'd2);
      cyc(1);
      drv(1, 1'b0, 2'b00, 16'h0400, 1'b1, 3'b000);
      cyc(3);

`ifdef AHB_ARB_FIXED_PRIO_EN
      m_req = 2'b11;
      cyc(1);
      for (int k = 0; k < 20; k++) begin
         chk("fp_gnt", 32'(m_gnt), 32'd1);
         cyc(1);
      end
      m_req[0] = 1'b0;
      cyc(1);
      chk("fp_hand", 32'(m_gnt), 32'd2);
      m_req = '0;
      cyc(2);
`else
      // saturate hold with singles, then INCR4 must not be split
      for (int k = 0; k < 7; k++)
         push(0, bl_addr[k], bl_tr[k], 1'b1, 32'h55000000 + 32'(k));
      push(1, 16'h0600, 2'b10, 1'b1, 32'h66666666);
      m_hwdata[63:32] = 32'h66666666;
      drv(1, 1'b1, 2'b10, 16'h0600, 1'b1, 3'b000);
      drv(0, 1'b1, bl_tr[0], bl_addr[0], 1'b1, bl_bu[0]);
      wait_gnt(0);
      for (int k = 0; k < 7; k++) begin
         chk("bl_gnt", 32'(m_gnt), 32'd1);
         cyc(1);
         m_hwdata[31:0] = 32'h55000000 + 32'(k);
         if (k < 6)
            drv(0, 1'b1, bl_tr[k+1], bl_addr[k+1], 1'b1, bl_bu[k+1]);
         else
            drv(0, 1'b0, 2'b00, bl_addr[k], 1'b1, 3'b000);
      end
      chk("bl_hand", 32'(m_gnt), 32'd2);
      cyc(1);
      drv(1, 1'b0, 2'b00, 16'h0600, 1'b1, 3'b000);
      cyc(3);
`endif

      // reset during a write data phase
      push(0, 16'h0700, 2'b10, 1'b1, 32'h77777777);
      m_hwdata[31:0] = 32'h77777777;
      drv(0, 1'b1, 2'b10, 16'h0700, 1'b1, 3'b000);
      wait_gnt(0);
      cyc(1);
      drv(0, 1'b0, 2'b00, 16'h0700, 1'b1, 3'b000);
      chk("rm_hwdata", HWDATA, 32'h77777777);
      HRESET = 1'b1;
      cyc(1);
      chk("rm_gnt", 32'(m_gnt), 32'd0);
      chk("rm_hsel", 32'(HSEL), 32'd0);
      chk("rm_hwdata0", HWDATA, 32'd0);
      HRESET = 1'b0;
      cyc(2);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
